md_ctrl: RTL and testbench

//  Multi-cycle multiply/divide scheduler for the 5-stage pipeline. Sits beside the E-stage ALU:

---
 rtl/md_ctrl.sv | 179 +++++++++++++++++
 tb/tb_md_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// Multiply/divide scheduler beside the E-stage ALU: computes mult/div results up front,
// releases them to HI/LO after a fixed busy countdown, and stalls D while it is occupied.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] num1,
    input  logic [31:0] num2,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_hi_n;
    logic [31:0]      r_lo_n;
    logic             r_commit;

    logic             w_is_md;
    logic [63:0]      w_smul;
    logic [63:0]      w_umul;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [31:0]      w_abs_a;
    logic [31:0]      w_abs_b;
    logic [31:0]      w_dnd;
    logic [31:0]      w_dsr;
    logic [31:0]      w_dsr_safe;
    logic [31:0]      w_q;
    logic [31:0]      w_r;
    logic [31:0]      w_res_hi;
    logic [31:0]      w_res_lo;
    logic             w_res_ok;

    assign w_is_md = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

    // Low 64 bits of a product of sign-extended operands equal the signed 64-bit product.
    assign w_smul = {{32{num1[31]}}, num1} * {{32{num2[31]}}, num2};
    assign w_umul = {32'd0, num1} * {32'd0, num2};

    // Signed division runs on magnitudes; signs are restored afterwards (truncate toward zero).
    assign w_a_neg    = num1[31];
    assign w_b_neg    = num2[31];
    assign w_abs_a    = w_a_neg ? (32'd0 - num1) : num1;
    assign w_abs_b    = w_b_neg ? (32'd0 - num2) : num2;
    assign w_dnd      = (op == OP_DIV) ? w_abs_a : num1;
    assign w_dsr      = (op == OP_DIV) ? w_abs_b : num2;
    assign w_dsr_safe = (w_dsr == 32'd0) ? 32'd1 : w_dsr;
    assign w_q        = w_dnd / w_dsr_safe;
    assign w_r        = w_dnd % w_dsr_safe;

    // Select the pending HI/LO value and whether it may be committed.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_res_ok = 1'b0;
        case (op)
            OP_MULT: begin
                w_res_hi = w_smul[63:32];
                w_res_lo = w_smul[31:0];
                w_res_ok = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_umul[63:32];
                w_res_lo = w_umul[31:0];
                w_res_ok = 1'b1;
            end
            OP_DIV: begin
                w_res_lo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q) : w_q;
                w_res_hi = w_a_neg ? (32'd0 - w_r) : w_r;
                w_res_ok = (num2 != 32'd0);
            end
            OP_DIVU: begin
                w_res_lo = w_q;
                w_res_hi = w_r;
                w_res_ok = (num2 != 32'd0);
            end
            default: begin
                w_res_hi = 32'd0;
                w_res_lo = 32'd0;
                w_res_ok = 1'b0;
            end
        endcase
    end

    // IDLE/RUN sequencer; a start seen while RUN is deliberately ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_hi_n   <= 32'd0;
            r_lo_n   <= 32'd0;
            r_commit <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                r_hi_n   <= w_res_hi;
                                r_lo_n   <= w_res_lo;
                                r_commit <= w_res_ok;
                                r_cnt    <= CNT_W'(MULT_CYCLES);
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            OP_DIV, OP_DIVU: begin
                                r_hi_n   <= w_res_hi;
                                r_lo_n   <= w_res_lo;
                                r_commit <= w_res_ok;
                                r_cnt    <= CNT_W'(DIV_CYCLES);
                                r_busy   <= 1'b1;
                                r_state  <= S_RUN;
                            end
                            OP_MTHI: r_hi <= num1;
                            OP_MTLO: r_lo <= num1;
                            default: r_state <= S_IDLE;
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        if (r_commit) begin
                            r_hi <= r_hi_n;
                            r_lo <= r_lo_n;
                        end else begin
                            r_hi <= r_hi;
                            r_lo <= r_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign stall = d_md_use & (r_busy | (start & w_is_md));

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: hand-computed HI/LO results, busy windows, stall and reset cases.
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        d_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .num1     (num1),
        .num2     (num2),
        .d_md_use (d_md_use),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one mult/div op, check the whole busy window, then the committed result.
    task automatic md_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n,
                         input logic [31:0] eh, input logic [31:0] el);
        start = 1'b1; op = o; num1 = a; num2 = b;
        #1;
        chk({tag, "_issue_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_issue_stall"}, {31'd0, stall}, {31'd0, d_md_use});
        tick();
        start = 1'b0; op = 3'd0;
        for (int i = 1; i <= n; i++) begin
            #1;
            chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
            chk({tag, "_stall"}, {31'd0, stall}, {31'd0, d_md_use});
            chk({tag, "_hi_old"}, hi, m_hi);
            chk({tag, "_lo_old"}, lo, m_lo);
            tick();
        end
        #1;
        chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        m_hi = eh;
        m_lo = el;
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 3'd0; num1 = 32'd0; num2 = 32'd0; d_md_use = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        tick(); tick();
        d_md_use = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0; d_md_use = 1'b0;
        tick();

        md_op("mult",  3'd1, 32'hFFFF_FFFE, 32'd3,        5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        md_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        d_md_use = 1'b1;
        md_op("div",   3'd3, 32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        d_md_use = 1'b0;
        md_op("divu0", 3'd4, 32'd7,         32'd0,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        md_op("divovf",3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
        md_op("divu",  3'd4, 32'hFFFF_FFFF, 32'h0000_0010, 10, 32'h0000_000F, 32'h0FFF_FFFF);
        md_op("divneg",3'd3, 32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);

        // mthi then mtlo back-to-back; neither raises busy nor stall
        d_md_use = 1'b1;
        start = 1'b1; op = 3'd5; num1 = 32'h0000_1234;
        #1;
        chk("mthi_stall", {31'd0, stall}, 32'd0);
        tick();
        op = 3'd6; num1 = 32'h0000_5678;
        #1;
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h0000_1234);
        tick();
        start = 1'b0; op = 3'd0;
        #1;
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_hi", hi, 32'h0000_1234);
        chk("mtlo_lo", lo, 32'h0000_5678);
        tick();

        // op 7 with start has no effect
        start = 1'b1; op = 3'd7; num1 = 32'hDEAD_BEEF; num2 = 32'd1;
        tick();
        start = 1'b0; op = 3'd0;
        #1;
        chk("op7_busy", {31'd0, busy}, 32'd0);
        chk("op7_hi", hi, 32'h0000_1234);
        chk("op7_lo", lo, 32'h0000_5678);
        tick();

        // starts during RUN are ignored: mult 2*3 must finish on its own schedule
        d_md_use = 1'b0;
        start = 1'b1; op = 3'd1; num1 = 32'd2; num2 = 32'd3;
        tick();
        start = 1'b0; op = 3'd0;
        tick();
        start = 1'b1; op = 3'd5; num1 = 32'hDEAD_0000;
        tick();
        op = 3'd1; num1 = 32'd100; num2 = 32'd100;
        tick();
        start = 1'b0; op = 3'd0;
        #1;
        chk("runign_busy4", {31'd0, busy}, 32'd1);
        chk("runign_hi_old", hi, 32'h0000_1234);
        tick();
        #1;
        chk("runign_busy5", {31'd0, busy}, 32'd1);
        tick();
        #1;
        chk("runign_done", {31'd0, busy}, 32'd0);
        chk("runign_hi", hi, 32'd0);
        chk("runign_lo", lo, 32'd6);
        tick();

        // reset at third busy cycle of a div aborts and discards the result
        start = 1'b1; op = 3'd3; num1 = 32'd100; num2 = 32'd7;
        tick();
        start = 1'b0; op = 3'd0;
        tick(); tick();
        #1;
        chk("abort_busy3", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("abort_late_hi", hi, 32'd0);
        chk("abort_late_lo", lo, 32'd0);
        chk("abort_late_busy", {31'd0, busy}, 32'd0);

        // reset and mthi on the same edge: reset wins
        rst = 1'b1; start = 1'b1; op = 3'd5; num1 = 32'h0000_ABCD;
        tick();
        rst = 1'b0; start = 1'b0; op = 3'd0;
        #1;
        chk("rstwin_hi", hi, 32'd0);
        chk("rstwin_busy", {31'd0, busy}, 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, expected completion before 100000");
        $fatal(1, "timeout");
    end

endmodule
